data_mem_responder: RTL

- Responder end of the CPU data-memory interface: accepts word-addressed load/store requests from the core and serves them from an internal word array.
- Response latency is configurable, so the multicycle/pipelined core can be exercised against non-zero-latency memory.
- Sits between the core's data port (address = ALU result, writedata, memwrite) and on-chip storage.
- Replaces the zero-wait data memory when the core runs the req/ready/resp_valid handshake.

---
 rtl/data_mem_responder.sv | 101 ++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-array data memory behind a req/ready handshake with
// a configurable number of wait cycles before each single-cycle response.
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 0..15");
  end

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [31:0]           r_addr;
  logic [3:0]            r_wstrb;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic [31:0]           r_mem [0:(1<<DEPTH_LOG2)-1];
  logic                  w_idle;
  logic                  w_acc;
  logic                  w_enter;
  logic                  w_we;
  logic                  w_err;
  logic [31:0]           w_addr;
  logic [31:0]           w_wdata;
  logic [3:0]            w_wstrb;
  logic [DEPTH_LOG2-1:0] w_idx;

  assign w_idle  = r_state == S_IDLE;
  assign w_acc   = w_idle & req;
  assign w_enter = w_next == S_RESP;
  // With zero wait cycles the access shares the accepting edge, so use the live request.
  assign w_we    = w_idle ? we : r_we;
  assign w_addr  = w_idle ? addr : r_addr;
  assign w_wstrb = w_idle ? wstrb : r_wstrb;
  assign w_wdata = w_idle ? wdata : r_wdata;
  assign w_idx   = w_addr[DEPTH_LOG2+1:2];
  assign w_err   = (w_addr[1:0] != 2'b00) | (w_addr[31:DEPTH_LOG2+2] != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wstrb <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_acc ? 4'(WAIT_CYCLES) : (r_state == S_WAIT ? r_cnt - 4'd1 : r_cnt);
      if (w_acc) begin
        r_we    <= we;
        r_addr  <= addr;
        r_wstrb <= wstrb;
        r_wdata <= wdata;
      end
      if (w_enter) begin
        r_rdata <= (w_we | w_err) ? '0 : r_mem[w_idx];
        r_err   <= w_err;
      end
    end
  end

  always_comb begin
    w_next = w_idle ? (req ? (WAIT_CYCLES == 0 ? S_RESP : S_WAIT) : S_IDLE) :
             r_state == S_WAIT ? (r_cnt == 4'd1 ? S_RESP : S_WAIT) : S_IDLE;
  end

  always_comb begin
    ready      = w_idle & ~rst;
    resp_valid = r_state == S_RESP;
    rdata      = resp_valid ? r_rdata : '0;
    err        = resp_valid & r_err;
  end

  always_ff @(posedge clk) begin
    if (w_enter & w_we & ~w_err & ~rst)
      for (int i = 0; i < 4; i++)
        if (w_wstrb[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
  end
endmodule
